// File: rtl/axi_id_remap_ctrl.sv
// AXI write-channel ID remapper: swaps wide AW IDs for compact table slots and
// restores them on B, with a flush handshake that quiesces the channel.
module axi_id_remap_ctrl #(
    parameter int ID_WIDTH_IN  = 8,
    parameter int ID_WIDTH_OUT = 6,
    parameter int AW_PL_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_aw_valid_i,
    output logic                    s_aw_ready_o,
    input  logic [ID_WIDTH_IN-1:0]  s_aw_id_i,
    input  logic [AW_PL_WIDTH-1:0]  s_aw_pl_i,
    output logic                    m_aw_valid_o,
    input  logic                    m_aw_ready_i,
    output logic [ID_WIDTH_OUT-1:0] m_aw_id_o,
    output logic [AW_PL_WIDTH-1:0]  m_aw_pl_o,
    input  logic                    m_b_valid_i,
    output logic                    m_b_ready_o,
    input  logic [ID_WIDTH_OUT-1:0] m_b_id_i,
    input  logic [1:0]              m_b_resp_i,
    output logic                    s_b_valid_o,
    input  logic                    s_b_ready_i,
    output logic [ID_WIDTH_IN-1:0]  s_b_id_o,
    output logic [1:0]              s_b_resp_o,
    output logic                    tbl_incr_o,
    output logic [ID_WIDTH_IN-1:0]  tbl_id_o,
    input  logic                    tbl_full_i,
    input  logic [ID_WIDTH_OUT-1:0] tbl_new_id_i,
    output logic                    tbl_release_o,
    output logic [ID_WIDTH_OUT-1:0] tbl_bid_o,
    input  logic [ID_WIDTH_IN-1:0]  tbl_orig_id_i,
    input  logic                    tbl_empty_i,
    input  logic                    flush_req_i,
    output logic                    flush_ack_o,
    output logic                    err_o
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state;
    logic   aw_hs;
    logic   b_hs;
    logic   drained;

    // tbl_full_i is the pre-release view, so a same-cycle release never unblocks AW
    assign s_aw_ready_o  = (state == RUN) & ~flush_req_i & ~tbl_full_i &
                           (~m_aw_valid_o | m_aw_ready_i);
    assign aw_hs         = s_aw_valid_i & s_aw_ready_o;
    assign tbl_incr_o    = aw_hs;
    assign tbl_id_o      = s_aw_id_i;

    assign m_b_ready_o   = ~s_b_valid_o | s_b_ready_i;
    assign b_hs          = m_b_valid_i & m_b_ready_o;
    assign tbl_release_o = b_hs;
    assign tbl_bid_o     = m_b_id_i;

    assign drained = tbl_empty_i & ~m_aw_valid_o & ~s_b_valid_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_aw_valid_o <= 1'b0;
            m_aw_id_o    <= '0;
            m_aw_pl_o    <= '0;
        end else if (aw_hs) begin
            m_aw_valid_o <= 1'b1;
            m_aw_id_o    <= tbl_new_id_i;
            m_aw_pl_o    <= s_aw_pl_i;
        end else if (m_aw_ready_i) begin
            m_aw_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_b_valid_o <= 1'b0;
            s_b_id_o    <= '0;
            s_b_resp_o  <= '0;
        end else if (b_hs) begin
            s_b_valid_o <= 1'b1;
            s_b_id_o    <= tbl_orig_id_i;
            s_b_resp_o  <= m_b_resp_i;
        end else if (s_b_ready_i) begin
            s_b_valid_o <= 1'b0;
        end
    end

    // A B with nothing outstanding is still forwarded; only the flag records it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_o <= 1'b0;
        else if (b_hs && tbl_empty_i)
            err_o <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            flush_ack_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_req_i) state <= DRAIN;
                    flush_ack_o <= 1'b0;
                end
                DRAIN: begin
                    // A withdrawn request wins over a simultaneous drain completion
                    if (!flush_req_i) begin
                        state       <= RUN;
                        flush_ack_o <= 1'b0;
                    end else if (drained) begin
                        state       <= DONE;
                        flush_ack_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush_req_i) begin
                        state       <= RUN;
                        flush_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= RUN;
                    flush_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_id_remap_ctrl.sv
// Bench for axi_id_remap_ctrl: a 4-slot lowest-free ID table model, a per-cycle
// vector table for the AW/B datapaths, and hand sequences for flush/error/reset.
module tb_axi_id_remap_ctrl;
    localparam int IW = 8, OW = 6, PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_aw_valid_i, s_aw_ready_o;
    logic [IW-1:0] s_aw_id_i;
    logic [PW-1:0] s_aw_pl_i;
    logic          m_aw_valid_o, m_aw_ready_i;
    logic [OW-1:0] m_aw_id_o;
    logic [PW-1:0] m_aw_pl_o;
    logic          m_b_valid_i, m_b_ready_o;
    logic [OW-1:0] m_b_id_i;
    logic [1:0]    m_b_resp_i;
    logic          s_b_valid_o, s_b_ready_i;
    logic [IW-1:0] s_b_id_o;
    logic [1:0]    s_b_resp_o;
    logic          tbl_incr_o, tbl_full_i, tbl_release_o, tbl_empty_i;
    logic [IW-1:0] tbl_id_o, tbl_orig_id_i;
    logic [OW-1:0] tbl_new_id_i, tbl_bid_o;
    logic          flush_req_i, flush_ack_o, err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_id_remap_ctrl #(.ID_WIDTH_IN(IW), .ID_WIDTH_OUT(OW), .AW_PL_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
        .s_aw_id_i(s_aw_id_i), .s_aw_pl_i(s_aw_pl_i),
        .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
        .m_aw_id_o(m_aw_id_o), .m_aw_pl_o(m_aw_pl_o),
        .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
        .m_b_id_i(m_b_id_i), .m_b_resp_i(m_b_resp_i),
        .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
        .s_b_id_o(s_b_id_o), .s_b_resp_o(s_b_resp_o),
        .tbl_incr_o(tbl_incr_o), .tbl_id_o(tbl_id_o), .tbl_full_i(tbl_full_i),
        .tbl_new_id_i(tbl_new_id_i), .tbl_release_o(tbl_release_o),
        .tbl_bid_o(tbl_bid_o), .tbl_orig_id_i(tbl_orig_id_i),
        .tbl_empty_i(tbl_empty_i), .flush_req_i(flush_req_i),
        .flush_ack_o(flush_ack_o), .err_o(err_o)
    );

    // 4-slot ID table: allocates the lowest free slot
    logic [3:0]    tv;
    logic [IW-1:0] torig [4];

    always_comb begin
        tbl_new_id_i = '0;
        for (int i = 3; i >= 0; i--)
            if (!tv[i]) tbl_new_id_i = OW'(i);
    end
    assign tbl_full_i    = &tv;
    assign tbl_empty_i   = ~|tv;
    assign tbl_orig_id_i = (tbl_bid_o < 4) ? torig[tbl_bid_o[1:0]] : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv <= '0;
        end else begin
            if (tbl_release_o && tbl_bid_o < 4) tv[tbl_bid_o[1:0]] <= 1'b0;
            if (tbl_incr_o) begin
                tv[tbl_new_id_i[1:0]]    <= 1'b1;
                torig[tbl_new_id_i[1:0]] <= tbl_id_o;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          awv; logic [IW-1:0] awid; logic mawr;
        logic          bv;  logic [OW-1:0] bid;  logic [1:0] bresp; logic sbr;
        logic          e_awrdy, e_incr, e_brdy, e_rel;
        logic          e_mawv; logic [OW-1:0] e_mawid; logic [IW-1:0] e_src;
        logic          e_sbv;  logic [IW-1:0] e_sbid;  logic [1:0] e_sresp;
    } vec_t;

    function automatic vec_t mk(
        logic awv, logic [7:0] awid, logic mawr, logic bv, logic [5:0] bid,
        logic [1:0] bresp, logic sbr, logic awrdy, logic incr, logic brdy, logic rel,
        logic mawv, logic [5:0] mawid, logic [7:0] src, logic sbv, logic [7:0] sbid,
        logic [1:0] sresp);
        vec_t v;
        v.awv = awv; v.awid = awid; v.mawr = mawr; v.bv = bv; v.bid = bid;
        v.bresp = bresp; v.sbr = sbr; v.e_awrdy = awrdy; v.e_incr = incr;
        v.e_brdy = brdy; v.e_rel = rel; v.e_mawv = mawv; v.e_mawid = mawid;
        v.e_src = src; v.e_sbv = sbv; v.e_sbid = sbid; v.e_sresp = sresp;
        return v;
    endfunction

    function automatic logic [PW-1:0] pl_of(logic [IW-1:0] id);
        return 32'hC0DE_0000 | {24'h0, id};
    endfunction

    vec_t vecs [25];

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic awv, logic [IW-1:0] awid, logic bv, logic [OW-1:0] bid,
                         logic fl);
        @(negedge clk);
        s_aw_valid_i = awv; s_aw_id_i = awid; s_aw_pl_i = pl_of(awid);
        m_b_valid_i = bv; m_b_id_i = bid; m_b_resp_i = 2'd0;
        m_aw_ready_i = 1'b1; s_b_ready_i = 1'b1; flush_req_i = fl;
        #1;
    endtask

    initial begin
        // awv id mawr | bv bid resp sbr | awrdy incr brdy rel | mawv mawid src | sbv sbid sresp
        vecs[0]  = mk(1,8'hA5,1, 0,0,0,1, 1,1,1,0, 1,0,8'hA5, 0,0,0);
        vecs[1]  = mk(0,8'h00,1, 0,0,0,1, 1,0,1,0, 0,0,0,     0,0,0);
        vecs[2]  = mk(0,8'h00,1, 1,0,0,1, 1,0,1,1, 0,0,0,     1,8'hA5,0);
        vecs[3]  = mk(0,8'h00,1, 0,0,0,1, 1,0,1,0, 0,0,0,     0,0,0);
        vecs[4]  = mk(1,8'h10,1, 0,0,0,1, 1,1,1,0, 1,0,8'h10, 0,0,0);
        vecs[5]  = mk(1,8'h11,1, 0,0,0,1, 1,1,1,0, 1,1,8'h11, 0,0,0);
        vecs[6]  = mk(1,8'h12,1, 0,0,0,1, 1,1,1,0, 1,2,8'h12, 0,0,0);
        vecs[7]  = mk(1,8'h13,1, 0,0,0,1, 1,1,1,0, 1,3,8'h13, 0,0,0);
        vecs[8]  = mk(1,8'h14,1, 0,0,0,1, 0,0,1,0, 0,0,0,     0,0,0);
        vecs[9]  = mk(1,8'h14,1, 1,2,2,1, 0,0,1,1, 0,0,0,     1,8'h12,2);
        vecs[10] = mk(1,8'h14,1, 0,0,0,1, 1,1,1,0, 1,2,8'h14, 0,0,0);
        vecs[11] = mk(0,8'h00,1, 0,0,0,1, 0,0,1,0, 0,0,0,     0,0,0);
        vecs[12] = mk(0,8'h00,1, 1,0,1,0, 0,0,1,1, 0,0,0,     1,8'h10,1);
        vecs[13] = mk(0,8'h00,1, 1,1,3,0, 1,0,0,0, 0,0,0,     1,8'h10,1);
        vecs[14] = mk(0,8'h00,1, 1,1,3,0, 1,0,0,0, 0,0,0,     1,8'h10,1);
        vecs[15] = mk(0,8'h00,1, 1,1,3,1, 1,0,1,1, 0,0,0,     1,8'h11,3);
        vecs[16] = mk(0,8'h00,1, 0,0,0,1, 1,0,1,0, 0,0,0,     0,0,0);
        vecs[17] = mk(1,8'h20,0, 0,0,0,1, 1,1,1,0, 1,0,8'h20, 0,0,0);
        vecs[18] = mk(1,8'h21,0, 0,0,0,1, 0,0,1,0, 1,0,8'h20, 0,0,0);
        vecs[19] = mk(1,8'h21,0, 0,0,0,1, 0,0,1,0, 1,0,8'h20, 0,0,0);
        vecs[20] = mk(1,8'h21,1, 0,0,0,1, 1,1,1,0, 1,1,8'h21, 0,0,0);
        vecs[21] = mk(0,8'h00,1, 0,0,0,1, 0,0,1,0, 0,0,0,     0,0,0);
        vecs[22] = mk(0,8'h00,1, 1,0,0,1, 0,0,1,1, 0,0,0,     1,8'h20,0);
        vecs[23] = mk(0,8'h00,1, 1,1,2,1, 1,0,1,1, 0,0,0,     1,8'h21,2);
        vecs[24] = mk(0,8'h00,1, 0,0,0,1, 1,0,1,0, 0,0,0,     0,0,0);

        rst_n = 1'b0;
        s_aw_valid_i = 0; s_aw_id_i = 0; s_aw_pl_i = 0; m_aw_ready_i = 1;
        m_b_valid_i = 0; m_b_id_i = 0; m_b_resp_i = 0; s_b_ready_i = 1; flush_req_i = 0;
        #1;
        chk("rst_m_aw_valid", m_aw_valid_o, 0);
        chk("rst_s_b_valid", s_b_valid_o, 0);
        chk("rst_flush_ack", flush_ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_s_aw_ready", s_aw_ready_o, 1);
        chk("rst_m_b_ready", m_b_ready_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            s_aw_valid_i = vecs[i].awv; s_aw_id_i = vecs[i].awid;
            s_aw_pl_i = pl_of(vecs[i].awid); m_aw_ready_i = vecs[i].mawr;
            m_b_valid_i = vecs[i].bv; m_b_id_i = vecs[i].bid;
            m_b_resp_i = vecs[i].bresp; s_b_ready_i = vecs[i].sbr;
            #1;
            chk($sformatf("v%0d_s_aw_ready", i), s_aw_ready_o, vecs[i].e_awrdy);
            chk($sformatf("v%0d_tbl_incr", i), tbl_incr_o, vecs[i].e_incr);
            chk($sformatf("v%0d_m_b_ready", i), m_b_ready_o, vecs[i].e_brdy);
            chk($sformatf("v%0d_tbl_release", i), tbl_release_o, vecs[i].e_rel);
            step_edge();
            chk($sformatf("v%0d_m_aw_valid", i), m_aw_valid_o, vecs[i].e_mawv);
            if (vecs[i].e_mawv) begin
                chk($sformatf("v%0d_m_aw_id", i), m_aw_id_o, vecs[i].e_mawid);
                chk($sformatf("v%0d_m_aw_pl", i), m_aw_pl_o, pl_of(vecs[i].e_src));
            end
            chk($sformatf("v%0d_s_b_valid", i), s_b_valid_o, vecs[i].e_sbv);
            if (vecs[i].e_sbv) begin
                chk($sformatf("v%0d_s_b_id", i), s_b_id_o, vecs[i].e_sbid);
                chk($sformatf("v%0d_s_b_resp", i), s_b_resp_o, vecs[i].e_sresp);
            end
            chk($sformatf("v%0d_err", i), err_o, 0);
            chk($sformatf("v%0d_flush_ack", i), flush_ack_o, 0);
        end

        // Flush with slots 2 (0x14) and 3 (0x13) outstanding
        drive(1, 8'h30, 0, 0, 1);
        chk("fl_aw_blocked_now", s_aw_ready_o, 0);
        chk("fl_no_incr", tbl_incr_o, 0);
        step_edge();
        chk("fl_ack_drain0", flush_ack_o, 0);
        drive(1, 8'h30, 1, 2, 1);
        chk("fl_b_ready", m_b_ready_o, 1);
        step_edge();
        chk("fl_b1_id", s_b_id_o, 8'h14);
        drive(1, 8'h30, 1, 3, 1);
        step_edge();
        chk("fl_b2_valid", s_b_valid_o, 1);
        chk("fl_b2_id", s_b_id_o, 8'h13);
        chk("fl_ack_drain1", flush_ack_o, 0);
        drive(1, 8'h30, 0, 0, 1);
        step_edge();
        chk("fl_b_left", s_b_valid_o, 0);
        chk("fl_ack_drain2", flush_ack_o, 0);
        drive(1, 8'h30, 0, 0, 1);
        chk("fl_aw_blocked_drain", s_aw_ready_o, 0);
        step_edge();
        chk("fl_ack_up", flush_ack_o, 1);
        drive(1, 8'h30, 0, 0, 0);
        chk("fl_aw_blocked_done", s_aw_ready_o, 0);
        step_edge();
        chk("fl_ack_down", flush_ack_o, 0);
        chk("fl_no_aw_yet", m_aw_valid_o, 0);
        drive(1, 8'h30, 0, 0, 0);
        chk("fl_aw_resumed", s_aw_ready_o, 1);
        step_edge();
        chk("fl_aw_valid", m_aw_valid_o, 1);
        chk("fl_aw_id", m_aw_id_o, 0);
        chk("fl_aw_pl", m_aw_pl_o, pl_of(8'h30));

        // Flush withdrawn during drain: back to RUN, no ack
        drive(0, 8'h00, 0, 0, 1);
        step_edge();
        chk("ab_ack0", flush_ack_o, 0);
        drive(0, 8'h00, 0, 0, 0);
        step_edge();
        chk("ab_ack1", flush_ack_o, 0);
        drive(0, 8'h00, 0, 0, 0);
        chk("ab_aw_ready", s_aw_ready_o, 1);

        // Error: legal B first, then one against an empty table
        drive(0, 8'h00, 1, 0, 0);
        step_edge();
        chk("er_legal_id", s_b_id_o, 8'h30);
        chk("er_legal_err", err_o, 0);
        drive(0, 8'h00, 1, 5, 0);
        chk("er_b_accepted", tbl_release_o, 1);
        step_edge();
        chk("er_set", err_o, 1);
        chk("er_b_forwarded", s_b_valid_o, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'h00, 0, 0, 0);
            step_edge();
            chk($sformatf("er_sticky%0d", k), err_o, 1);
        end

        // Async reset clears everything mid-cycle
        drive(1, 8'h40, 1, 0, 0);
        step_edge();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_err", err_o, 0);
        chk("rr_m_aw_valid", m_aw_valid_o, 0);
        chk("rr_s_b_valid", s_b_valid_o, 0);
        chk("rr_flush_ack", flush_ack_o, 0);
        chk("rr_s_aw_ready", s_aw_ready_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete, checks %0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/axi_id_remap_ctrl.md
# axi_id_remap_ctrl

AXI write-channel ID remapping controller. It sequences an external ID table, sitting between a slave-side AW/B port pair and a master-side AW/B port pair. Each accepted AW has its wide ID replaced by a compact table index. Each B response gets its original ID restored and its table slot freed. A flush handshake quiesces the channel, e.g. before reconfiguration or power-down.

## Interface
Parameters:
- ID_WIDTH_IN, 8, slave-side (original) AXI ID width
- ID_WIDTH_OUT, 6, master-side (remapped) AXI ID width
- AW_PL_WIDTH, 32, opaque AW payload width (addr/len/size/burst…), passed through unchanged

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_aw_valid_i / s_aw_ready_o  in/out  1  slave AW handshake
- s_aw_id_i  in  ID_WIDTH_IN  original AW ID
- s_aw_pl_i  in  AW_PL_WIDTH  AW payload
- m_aw_valid_o / m_aw_ready_i  out/in  1  master AW handshake
- m_aw_id_o  out  ID_WIDTH_OUT  remapped AW ID
- m_aw_pl_o  out  AW_PL_WIDTH  AW payload
- m_b_valid_i / m_b_ready_o  in/out  1  master B handshake
- m_b_id_i  in  ID_WIDTH_OUT  remapped B ID
- m_b_resp_i  in  2  B response
- s_b_valid_o / s_b_ready_i  out/in  1  slave B handshake
- s_b_id_o  out  ID_WIDTH_IN  restored B ID
- s_b_resp_o  out  2  B response
- tbl_incr_o  out  1  allocate table slot this cycle
- tbl_id_o  out  ID_WIDTH_IN  original ID stored at allocation
- tbl_full_i  in  1  no free slot
- tbl_new_id_i  in  ID_WIDTH_OUT  index of the slot being allocated; combinational from table state
- tbl_release_o  out  1  free slot tbl_bid_o this cycle
- tbl_bid_o  out  ID_WIDTH_OUT  slot to look up/free
- tbl_orig_id_i  in  ID_WIDTH_IN  stored original ID at tbl_bid_o; combinational
- tbl_empty_i  in  1  no slot valid
- flush_req_i  in  1  flush request, level
- flush_ack_o  out  1  channel quiesced, registered
- err_o  out  1  sticky protocol error

## Operation
- AW path: one-entry output register.
  - s_aw_ready_o = (state==RUN) & ~flush_req_i & ~tbl_full_i & (~m_aw_valid_o | m_aw_ready_i).
  - On a slave AW handshake, in the same cycle: tbl_incr_o=1, tbl_id_o=s_aw_id_i.
  - The register captures m_aw_id_o<=tbl_new_id_i and m_aw_pl_o<=s_aw_pl_i, and sets m_aw_valid_o.
  - Otherwise m_aw_valid_o clears on m_aw_ready_i.
  - tbl_incr_o is never asserted without a handshake.
- B path: one-entry output register.
  - m_b_ready_o = ~s_b_valid_o | s_b_ready_i; tbl_bid_o = m_b_id_i always.
  - On a master B handshake, in the same cycle: tbl_release_o=1.
  - The register captures s_b_id_o<=tbl_orig_id_i and s_b_resp_o<=m_b_resp_i, and sets s_b_valid_o.
  - Otherwise s_b_valid_o clears on s_b_ready_i.
- Simultaneous allocate and release in one cycle is legal; both strobes are asserted.
  - tbl_full_i reflects the pre-release state, so a full table still blocks AW that cycle.
- err_o is set when a master B handshake occurs while tbl_empty_i=1. It is cleared only by reset. That B is still forwarded, with tbl_orig_id_i as read.
- Flush FSM has three states: RUN, DRAIN, DONE.
  - RUN -> DRAIN when flush_req_i=1.
  - DRAIN -> DONE when tbl_empty_i & ~m_aw_valid_o & ~s_b_valid_o.
  - DONE -> RUN when flush_req_i=0.
  - flush_ack_o = (state==DONE).
  - The B path keeps running in DRAIN and DONE. AW is blocked in DRAIN and DONE, and combinationally whenever flush_req_i=1.
  - flush_req_i dropping during DRAIN returns the FSM to RUN without ack.

## Timing
- Reset values:
  - m_aw_valid_o=0, s_b_valid_o=0, flush_ack_o=0, err_o=0.
  - State RUN; all data registers 0.
  - s_aw_ready_o=~tbl_full_i&~flush_req_i; m_b_ready_o=1.
- AW latency: 1 cycle from slave handshake to m_aw_valid_o. Full throughput of 1 AW/cycle with m_aw_ready_i held high.
- B latency: 1 cycle from master handshake to s_b_valid_o. Full throughput of 1 B/cycle.
- Ready outputs are combinational from registered state and the listed inputs only. There is no valid->ready path on the same channel.
- flush_ack_o rises 1 cycle after the drain condition is met. It falls 1 cycle after flush_req_i drops.
- Reset mid-transfer drops all in-flight beats. The table is reset by the same rst_n.

## Test plan
- Single write, 4-slot table:
  - Stimulus: AW id 0xA5; then B with m_b_id_i=0, resp 0.
  - Response: m_aw_id_o=0 one cycle after handshake, tbl_incr_o pulses once; s_b_id_o=0xA5 one cycle after B handshake, tbl_release_o pulses, tbl_empty_i returns to 1.
- Fill to full:
  - Stimulus: 5 back-to-back AWs, ids 0x10–0x14.
  - Response: first four remap to 0–3 on consecutive cycles; s_aw_ready_o=0 for 0x14 until a B frees a slot; 0x14 then takes the freed index.
- Backpressure:
  - Stimulus: hold m_aw_ready_i=0 for 3 cycles, s_b_ready_i=0 for 3 cycles.
  - Response: payload/ID stable, s_aw_ready_o and m_b_ready_o low while registers are full; no extra tbl strobes.
- Same-cycle alloc+release at full:
  - Stimulus: table full, AW pending, B for slot 2.
  - Response: AW not accepted that cycle; accepted next cycle with m_aw_id_o=2.
- Flush:
  - Stimulus: flush_req_i=1 with 2 outstanding writes.
  - Response: AW blocked immediately; flush_ack_o=1 one cycle after the second B leaves s_b; flush_req_i=0 -> ack drops, AW resumes.
- Error:
  - Stimulus: B with empty table.
  - Response: err_o=1 the next cycle and stays 1 until reset.
